// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the Y86 memory-stage access controller:
// data width, instruction codes, status codes and FSM state encoding.
package mem_access_ctrl_pkg;

  localparam int DATA_WID = 64;

  localparam logic [3:0] IC_HALT   = 4'h0;
  localparam logic [3:0] IC_NOP    = 4'h1;
  localparam logic [3:0] IC_RRMOVQ = 4'h2;
  localparam logic [3:0] IC_IRMOVQ = 4'h3;
  localparam logic [3:0] IC_RMMOVQ = 4'h4;
  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_OPQ    = 4'h6;
  localparam logic [3:0] IC_JXX    = 4'h7;
  localparam logic [3:0] IC_CALL   = 4'h8;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_PUSHQ  = 4'hA;
  localparam logic [3:0] IC_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the operation handshake, data-memory bus and result handshake.
// The controller uses the slave view; the pipeline/memory model uses master.
interface mem_access_ctrl_if;

  logic                                     in_valid;
  logic                                     in_ready;
  logic [3:0]                               icode;
  logic [mem_access_ctrl_pkg::DATA_WID-1:0] valE;
  logic [mem_access_ctrl_pkg::DATA_WID-1:0] valA;
  logic [mem_access_ctrl_pkg::DATA_WID-1:0] valP;
  logic [mem_access_ctrl_pkg::DATA_WID-1:0] mem_addr;
  logic [mem_access_ctrl_pkg::DATA_WID-1:0] mem_wdata;
  logic                                     mem_write;
  logic                                     mem_read;
  logic                                     mem_ack;
  logic [mem_access_ctrl_pkg::DATA_WID-1:0] mem_rdata;
  logic                                     mem_error;
  logic                                     out_valid;
  logic                                     out_ready;
  logic [mem_access_ctrl_pkg::DATA_WID-1:0] valM;
  logic [2:0]                               stat;

  modport slave (
    input  in_valid, icode, valE, valA, valP,
    input  mem_ack, mem_rdata, mem_error, out_ready,
    output in_ready, mem_addr, mem_wdata, mem_write, mem_read,
    output out_valid, valM, stat
  );

  modport master (
    output in_valid, icode, valE, valA, valP,
    output mem_ack, mem_rdata, mem_error, out_ready,
    input  in_ready, mem_addr, mem_wdata, mem_write, mem_read,
    input  out_valid, valM, stat
  );

endinterface

// File: rtl/mem_op_decode.sv
// Combinational decode of a Y86 memory-stage operation into a read or write
// request with its address and write data. Non-memory icodes yield no request.
module mem_op_decode
  import mem_access_ctrl_pkg::*;
(
  input  logic [3:0]          i_icode,
  input  logic [DATA_WID-1:0] i_valE,
  input  logic [DATA_WID-1:0] i_valA,
  input  logic [DATA_WID-1:0] i_valP,
  output logic                o_is_read,
  output logic                o_is_write,
  output logic [DATA_WID-1:0] o_addr,
  output logic [DATA_WID-1:0] o_wdata
);

  // Map icode to direction, address and write data
  always_comb begin
    o_is_read  = 1'b0;
    o_is_write = 1'b0;
    o_addr     = '0;
    o_wdata    = '0;
    unique case (i_icode)
      IC_RMMOVQ, IC_PUSHQ: begin
        o_is_write = 1'b1;
        o_addr     = i_valE;
        o_wdata    = i_valA;
      end
      IC_CALL: begin
        o_is_write = 1'b1;
        o_addr     = i_valE;
        o_wdata    = i_valP;
      end
      IC_MRMOVQ: begin
        o_is_read = 1'b1;
        o_addr    = i_valE;
      end
      IC_POPQ, IC_RET: begin
        o_is_read = 1'b1;
        o_addr    = i_valA;
      end
      default: begin
        o_is_read  = 1'b0;
        o_is_write = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: accepts one Y86 operation at a time, issues
// a single read or write to data memory, waits for the acknowledge (bounded by
// TIMEOUT cycles) and presents valM/stat on a valid/ready result handshake.
// All outputs are registered so they are clean zeros while reset is held.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
)
(
  input  logic         CLK,
  input  logic         RST_N,
  mem_access_ctrl_if.slave bus
);

  // A zero TIMEOUT still needs a one-bit counter
  localparam int               CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [DATA_WID-1:0]   r_addr, w_addr_nxt;
  logic [DATA_WID-1:0]   r_wdata, w_wdata_nxt;
  logic                  r_read, w_read_nxt;
  logic                  r_write, w_write_nxt;
  logic [DATA_WID-1:0]   r_valM, w_valM_nxt;
  logic [2:0]            r_stat, w_stat_nxt;
  logic                  r_in_ready, w_in_ready_nxt;
  logic                  r_out_valid, w_out_valid_nxt;

  logic                  w_is_read, w_is_write;
  logic [DATA_WID-1:0]   w_dec_addr, w_dec_wdata;
  logic                  w_accept;

  mem_op_decode u_decode (
    .i_icode    (bus.icode),
    .i_valE     (bus.valE),
    .i_valA     (bus.valA),
    .i_valP     (bus.valP),
    .o_is_read  (w_is_read),
    .o_is_write (w_is_write),
    .o_addr     (w_dec_addr),
    .o_wdata    (w_dec_wdata)
  );

  // in_ready is registered, so it is also the "accepting" qualifier
  assign w_accept = bus.in_valid & r_in_ready;

  // Saturating wait-counter increment; never wraps back to zero
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  // Next-state and next-output logic for the IDLE/ACCESS/DONE sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_read_nxt  = r_read;
    w_write_nxt = r_write;
    w_valM_nxt  = r_valM;
    w_stat_nxt  = r_stat;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_read | w_is_write) begin
            w_addr_nxt  = w_dec_addr;
            w_wdata_nxt = w_dec_wdata;
            w_read_nxt  = w_is_read;
            w_write_nxt = w_is_write;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_ACCESS;
          end else begin
            w_valM_nxt  = '0;
            w_stat_nxt  = STAT_AOK;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_ACCESS: begin
        w_cnt_nxt = w_cnt_inc;
        // Acknowledge is checked first so it wins over a coincident timeout
        if (bus.mem_ack) begin
          w_valM_nxt  = r_read ? bus.mem_rdata : '0;
          w_stat_nxt  = bus.mem_error ? STAT_ADR : STAT_AOK;
          w_read_nxt  = 1'b0;
          w_write_nxt = 1'b0;
          w_state_nxt = ST_DONE;
        end else if (w_cnt_inc == CNT_MAX) begin
          w_valM_nxt  = '0;
          w_stat_nxt  = STAT_ADR;
          w_read_nxt  = 1'b0;
          w_write_nxt = 1'b0;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_in_ready_nxt  = (w_state_nxt == ST_IDLE);
    w_out_valid_nxt = (w_state_nxt == ST_DONE);
  end

  // State and registered outputs; reset clears everything immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_valM      <= '0;
      r_stat      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_read      <= w_read_nxt;
      r_write     <= w_write_nxt;
      r_valM      <= w_valM_nxt;
      r_stat      <= w_stat_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_read  = r_read;
  assign bus.mem_write = r_write;
  assign bus.out_valid = r_out_valid;
  assign bus.valM      = r_valM;
  assign bus.stat      = r_stat;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios followed by randomized
// operations, each compared against a transaction-level expectation.
module tb_mem_access_ctrl;

  localparam int TMO = 15;

  logic CLK;
  logic RST_N;
  int   n_vec;
  int   n_err;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Operation table: which icodes touch memory, where, and with what data
  task automatic ref_decode(input logic [3:0] ic, input logic [63:0] ve, va, vp,
                            output logic rd, output logic wr,
                            output logic [63:0] addr, output logic [63:0] wd);
    rd = 0; wr = 0; addr = 0; wd = 0;
    case (ic)
      4'h4, 4'hA: begin wr = 1; addr = ve; wd = va; end
      4'h8:       begin wr = 1; addr = ve; wd = vp; end
      4'h5:       begin rd = 1; addr = ve; end
      4'h9, 4'hB: begin rd = 1; addr = va; end
      default: ;
    endcase
  endtask

  // One full transaction: accept, access (ack in ACCESS cycle ack_cyc, 0 = never),
  // then DONE held for 'hold' cycles of out_ready=0 before release.
  task automatic run_op(input logic [3:0] ic, input logic [63:0] ve, va, vp, rdat,
                        input int ack_cyc, input logic er, input int hold);
    logic        e_rd, e_wr;
    logic [63:0] e_addr, e_wd, e_valm;
    logic [2:0]  e_stat;
    int          e_cyc, cyc, w;
    ref_decode(ic, ve, va, vp, e_rd, e_wr, e_addr, e_wd);
    if (!(e_rd || e_wr)) begin
      e_cyc = 0; e_valm = 0; e_stat = 3'd1;
    end else if (ack_cyc >= 1 && ack_cyc <= TMO) begin
      e_cyc = ack_cyc; e_valm = e_rd ? rdat : 64'd0; e_stat = er ? 3'd3 : 3'd1;
    end else begin
      e_cyc = TMO; e_valm = 0; e_stat = 3'd3;
    end

    w = 0;
    while (!bus.in_ready && w < 50) begin tick(); w++; end
    chk("in_ready_idle", bus.in_ready, 1);

    bus.in_valid = 1; bus.icode = ic; bus.valE = ve; bus.valA = va; bus.valP = vp;
    tick();
    bus.in_valid = 0; bus.icode = $urandom_range(0, 15);
    chk("in_ready_busy", bus.in_ready, 0);

    cyc = 0;
    while ((bus.mem_read || bus.mem_write) && cyc < 40) begin
      chk("mem_read", bus.mem_read, e_rd);
      chk("mem_write", bus.mem_write, e_wr);
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_wdata", bus.mem_wdata, e_wd);
      chk("out_valid_access", bus.out_valid, 0);
      bus.mem_ack   = (cyc + 1 == ack_cyc);
      bus.mem_error = bus.mem_ack ? er : ~er;
      bus.mem_rdata = bus.mem_ack ? rdat : ~rdat;
      tick();
      cyc++;
    end
    bus.mem_ack = 0;
    chk("access_cycles", cyc, e_cyc);
    chk("out_valid", bus.out_valid, 1);
    chk("valM", bus.valM, e_valm);
    chk("stat", bus.stat, e_stat);
    chk("strobes_done", {bus.mem_read, bus.mem_write}, 0);

    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 0;
      bus.mem_ack   = 1'($urandom_range(0, 1));
      bus.mem_rdata = {$urandom, $urandom};
      tick();
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_valM", bus.valM, e_valm);
      chk("hold_stat", bus.stat, e_stat);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.mem_ack = 0;
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    chk("released_out_valid", bus.out_valid, 0);
    chk("released_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.in_valid = 0; bus.icode = 0; bus.valE = 0; bus.valA = 0; bus.valP = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0; bus.mem_error = 0; bus.out_ready = 0;
    RST_N = 0;
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    RST_N = 1;
    chk("release_in_ready_pre_edge", bus.in_ready, 0);
    tick();
    chk("release_in_ready", bus.in_ready, 1);
    chk("release_out_valid", bus.out_valid, 0);
    chk("release_valM", bus.valM, 0);
    chk("release_stat", bus.stat, 0);
    chk("release_strobes", {bus.mem_read, bus.mem_write}, 0);
    chk("release_addr", bus.mem_addr, 0);
    chk("release_wdata", bus.mem_wdata, 0);

    // mrmovq, ack in third ACCESS cycle, data 0x55
    run_op(4'h5, 64'd4, 64'd0, 64'd0, 64'h55, 3, 1'b0, 0);
    // call, immediate ack
    run_op(4'h8, 64'd8, 64'd0, 64'h20, 64'hDEAD, 1, 1'b0, 0);
    // popq with address fault
    run_op(4'hB, 64'd0, 64'd12, 64'd0, 64'h77, 1, 1'b1, 0);
    // rmmovq timeout, then ack exactly in the last allowed cycle
    run_op(4'h4, 64'h100, 64'hABCD, 64'd0, 64'd0, 0, 1'b0, 0);
    run_op(4'h4, 64'h100, 64'hABCD, 64'd0, 64'd0, TMO, 1'b0, 0);
    // non-memory op, then backpressure with stray acks in DONE
    run_op(4'h1, 64'h9, 64'h9, 64'h9, 64'h9, 1, 1'b0, 0);
    run_op(4'h9, 64'd0, 64'h40, 64'd0, 64'h1234, 2, 1'b0, 5);

    // Reset pulsed during ACCESS drops the strobes without a clock edge
    bus.in_valid = 1; bus.icode = 4'hA; bus.valE = 64'h80; bus.valA = 64'h5; bus.valP = 0;
    tick();
    bus.in_valid = 0;
    tick();
    chk("abort_write_before", bus.mem_write, 1);
    #2 RST_N = 0;
    #1;
    chk("abort_write", bus.mem_write, 0);
    chk("abort_read", bus.mem_read, 0);
    chk("abort_addr", bus.mem_addr, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    tick();
    RST_N = 1;
    chk("abort_in_ready_pre_edge", bus.in_ready, 0);
    tick();
    chk("abort_in_ready_post", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 18),
             1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
